if_fetch_unit: RTL and testbench

- Instruction fetch stage; produces the instruction/PC packet that the decode stage consumes.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers fetched instructions in a small FIFO so decode stalls do not drop data.
- Handles redirects from branch/jump resolution and stops fetching when decode flags a halt.

---
 rtl/if_fetch_unit_if.sv | 35 +++
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory request/response channel,
// redirect/halt controls from later stages, and the packet handed to decode.
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic                  id_ready;
  logic                  if_valid;
  logic [31:0]           if_inst;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [ADDR_WIDTH-1:0] if_npc;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    output if_valid, if_inst, if_pc, if_npc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, halt, id_ready
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_inst, if_pc, if_npc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, halt, id_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one word fetch in
// flight, and buffers returned instructions in a small FIFO for decode.
module if_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h0000_0000_8000_0000),
  parameter int                    FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  if_fetch_unit_if.master  fu
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALTED} state_t;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_pc_q;
  logic                  drop_q, drop_d;
  logic                  halt_q;

  fq_entry_t [FIFO_DEPTH-1:0] fq_mem;
  logic [PTR_W-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]           cnt_q;
  fq_entry_t                  head;

  logic                  halt_any, redir, req_valid, req_fire, rsp_fire, push, pop;
  logic [ADDR_WIDTH-1:0] redir_pc_al;
  logic                  unused_redir_lo;

  assign halt_any    = fu.halt | halt_q;
  assign redir       = fu.redirect_valid;
  assign redir_pc_al = {fu.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_lo = ^fu.redirect_pc[1:0];

  // Issue only from FETCH with a free FIFO slot reserved for the response;
  // held quiet while reset is asserted.
  assign req_valid = rst_n && (state_q == S_FETCH) && (cnt_q < CNT_W'(FIFO_DEPTH))
                     && !redir && !halt_any;
  assign req_fire  = req_valid && fu.imem_req_ready;
  // Responses outside WAIT (e.g. stragglers across a reset) are ignored.
  assign rsp_fire  = (state_q == S_WAIT) && fu.imem_rsp_valid;
  // Redirect wins over both ends of the FIFO: it flushes everything.
  assign push      = rsp_fire && !drop_q && !redir;
  assign pop       = (cnt_q != '0) && fu.id_ready && !redir;

  assign fu.imem_req_valid = req_valid;
  assign fu.imem_req_addr  = pc_q;

  assign head        = fq_mem[rd_ptr_q];
  assign fu.if_valid = (cnt_q != '0);
  assign fu.if_inst  = fu.if_valid ? head.inst : '0;
  assign fu.if_pc    = fu.if_valid ? head.pc   : '0;
  assign fu.if_npc   = fu.if_pc + ADDR_WIDTH'(4);

  // Next-state, next-PC and drop-flag logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redir)         pc_d = redir_pc_al;
    else if (req_fire) pc_d = pc_q + ADDR_WIDTH'(4);
    case (state_q)
      S_FETCH: begin
        if (req_fire)      state_d = S_WAIT;
        else if (halt_any) state_d = S_HALTED;
      end
      S_WAIT: begin
        if (fu.imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = halt_any ? S_HALTED : S_FETCH;
        end else if (redir) begin
          // Response still in flight belongs to the old path.
          drop_d = 1'b1;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (req_fire) req_pc_q <= pc_q;
      if (fu.halt)  halt_q   <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (redir) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head
  always_ff @(posedge clk) begin
    if (push) fq_mem[wr_ptr_q] <= '{inst: fu.imem_rsp_data, pc: req_pc_q};
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for the fetch stage: a table of per-cycle input/expected
// output records followed by hand-written reset and PC-wrap sequences.
module tb_if_fetch_unit;
  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_WIDTH(64)) bus ();

  if_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fu    (bus)
  );

  typedef struct {
    string       nm;
    bit          rdy, rv;
    logic [31:0] rd;
    bit          redir;
    logic [63:0] rpc;
    bit          hlt, idr;
    bit          e_rqv;
    logic [63:0] e_addr;
    bit          e_ifv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  vec_t tv[$];

  function automatic vec_t mk(string nm, bit rdy, bit rv, logic [31:0] rd, bit redir,
                              logic [63:0] rpc, bit hlt, bit idr, bit e_rqv,
                              logic [63:0] e_addr, bit e_ifv, logic [31:0] e_inst,
                              logic [63:0] e_pc);
    vec_t t;
    t.nm = nm; t.rdy = rdy; t.rv = rv; t.rd = rd; t.redir = redir; t.rpc = rpc;
    t.hlt = hlt; t.idr = idr; t.e_rqv = e_rqv; t.e_addr = e_addr;
    t.e_ifv = e_ifv; t.e_inst = e_inst; t.e_pc = e_pc;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, ".req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    chk({nm, ".if_valid"},  64'(bus.if_valid),       64'd0);
    chk({nm, ".if_inst"},   64'(bus.if_inst),        64'd0);
    chk({nm, ".if_pc"},     bus.if_pc,               64'd0);
    chk({nm, ".if_npc"},    bus.if_npc,              64'd4);
  endtask

  // Called at a negedge: drive the cycle's inputs, check outputs, advance.
  task automatic run(vec_t t);
    logic [63:0] exp_pc;
    bus.imem_req_ready = t.rdy;
    bus.imem_rsp_valid = t.rv;
    bus.imem_rsp_data  = t.rd;
    bus.redirect_valid = t.redir;
    bus.redirect_pc    = t.rpc;
    bus.halt           = t.hlt;
    bus.id_ready       = t.idr;
    #1;
    exp_pc = t.e_ifv ? t.e_pc : 64'd0;
    chk({t.nm, ".req_valid"}, 64'(bus.imem_req_valid), 64'(t.e_rqv));
    if (t.e_rqv) chk({t.nm, ".req_addr"}, bus.imem_req_addr, t.e_addr);
    chk({t.nm, ".if_valid"}, 64'(bus.if_valid), 64'(t.e_ifv));
    chk({t.nm, ".if_inst"},  64'(bus.if_inst),  64'(t.e_ifv ? t.e_inst : 32'd0));
    chk({t.nm, ".if_pc"},    bus.if_pc,         exp_pc);
    chk({t.nm, ".if_npc"},   bus.if_npc,        exp_pc + 64'd4);
    @(negedge clk);
  endtask

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA111_1111,
                          A2 = 32'hA222_2222, A3 = 32'hA333_3333,
                          B0 = 32'hB000_0000, B1 = 32'hB111_1111,
                          C0 = 32'hC000_0000, C1 = 32'hC111_1111,
                          D0 = 32'hD000_0000, D1 = 32'hD111_1111,
                          E0 = 32'hE000_0000;

  initial begin
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt = 0; bus.id_ready = 0;

    // name, rdy rv rd, redir rpc, hlt idr, e_rqv e_addr, e_ifv e_inst e_pc
    tv.push_back(mk("boot_req",   1,0,0,  0,0, 0,1, 1,B,      0,0,0));
    tv.push_back(mk("rsp0",       1,1,A0, 0,0, 0,1, 0,0,      0,0,0));
    tv.push_back(mk("req1",       1,0,0,  0,0, 0,1, 1,B+4,    1,A0,B));
    tv.push_back(mk("rsp1",       1,1,A1, 0,0, 0,1, 0,0,      0,0,0));
    tv.push_back(mk("req2",       1,0,0,  0,0, 0,1, 1,B+8,    1,A1,B+4));
    tv.push_back(mk("rsp2",       1,1,A2, 0,0, 0,1, 0,0,      0,0,0));
    tv.push_back(mk("stall_req",  1,0,0,  0,0, 0,0, 1,B+12,   1,A2,B+8));
    tv.push_back(mk("stall_rsp",  1,1,A3, 0,0, 0,0, 0,0,      1,A2,B+8));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk("stall_full", 1,0,0, 0,0, 0,0, 0,0,     1,A2,B+8));
    tv.push_back(mk("drain0",     0,0,0,  0,0, 0,1, 0,0,      1,A2,B+8));
    tv.push_back(mk("drain1",     1,0,0,  0,0, 0,0, 1,B+16,   1,A3,B+12));
    tv.push_back(mk("redir_wait", 0,0,0,  1,B+'h103, 0,0, 0,0, 1,A3,B+12));
    tv.push_back(mk("late_rsp",   0,1,32'hDEAD_BEEF, 0,0, 0,1, 0,0, 0,0,0));
    tv.push_back(mk("redir_req",  1,0,0,  0,0, 0,1, 1,B+'h100, 0,0,0));
    tv.push_back(mk("redir_rsp",  1,1,B0, 0,0, 0,1, 0,0,      0,0,0));
    tv.push_back(mk("pre_full",   1,0,0,  0,0, 0,0, 1,B+'h104, 1,B0,B+'h100));
    tv.push_back(mk("redir_rsp_same", 0,1,B1, 1,B+'h200, 0,1, 0,0, 1,B0,B+'h100));
    tv.push_back(mk("redir2_req", 1,0,0,  0,0, 0,1, 1,B+'h200, 0,0,0));
    tv.push_back(mk("redir2_rsp", 1,1,C0, 0,0, 0,1, 0,0,      0,0,0));
    tv.push_back(mk("halt_pre",   1,0,0,  0,0, 0,0, 1,B+'h204, 1,C0,B+'h200));
    tv.push_back(mk("halt_wait",  1,0,0,  0,0, 1,0, 0,0,      1,C0,B+'h200));
    tv.push_back(mk("halt_rsp",   1,1,C1, 0,0, 0,0, 0,0,      1,C0,B+'h200));
    tv.push_back(mk("halt_drain0",1,0,0,  0,0, 0,1, 0,0,      1,C0,B+'h200));
    tv.push_back(mk("halt_drain1",1,0,0,  0,0, 0,1, 0,0,      1,C1,B+'h204));
    tv.push_back(mk("halt_redir", 1,0,0,  1,B+'h300, 0,1, 0,0, 0,0,0));
    tv.push_back(mk("halt_stay0", 1,0,0,  0,0, 0,1, 0,0,      0,0,0));
    tv.push_back(mk("halt_stay1", 1,0,0,  0,0, 0,1, 0,0,      0,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) run(tv[i]);

    // Reset dropped while a fetch is outstanding with a packet buffered
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(mk("r_req",   1,0,0,  0,0, 0,0, 1,B,   0,0,0));
    run(mk("r_rsp",   1,1,D0, 0,0, 0,0, 0,0,   0,0,0));
    run(mk("r_req2",  1,0,0,  0,0, 0,0, 1,B+4, 1,D0,B));
    bus.imem_req_ready = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(mk("stray_rsp",   0,1,32'hBAD0_0000, 0,0, 0,1, 1,B, 0,0,0));
    run(mk("after_stray", 1,0,0,  0,0, 0,1, 1,B,   0,0,0));
    run(mk("post_rsp",    1,1,D1, 0,0, 0,1, 0,0,   0,0,0));
    run(mk("post_chk",    0,0,0,  0,0, 0,1, 1,B+4, 1,D1,B));

    // PC wrap; unaligned redirect target is forced to a word boundary
    run(mk("wrap_redir", 0,0,0,  1,64'hFFFF_FFFF_FFFF_FFFF, 0,1, 0,0, 0,0,0));
    run(mk("wrap_req",   1,0,0,  0,0, 0,1, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0));
    run(mk("wrap_rsp",   1,1,E0, 0,0, 0,1, 0,0, 0,0,0));
    run(mk("wrap_next",  0,0,0,  0,0, 0,1, 1,64'd0, 1,E0,64'hFFFF_FFFF_FFFF_FFFC));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
